// File: rtl/hierIncludeC_package.sv
// Shared types for the block C req/ack responder: payload layouts, op codes and FSM states.
package hierIncludeC_package;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned REQ_W  = 1 + ADDR_W + DATA_W;
  localparam int unsigned ACK_W  = 1 + DATA_W;
  localparam int unsigned NTF_W  = ADDR_W + DATA_W;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  typedef struct packed {
    op_e               op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  typedef struct packed {
    logic              err;
    logic [DATA_W-1:0] rdata;
  } ack_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } ntf_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BUSY,
    ST_NOTIFY,
    ST_ACK,
    ST_WAIT_DROP
  } state_e;

endpackage

// File: rtl/blockc_regarray.sv
// Register file: one synchronous write port, one combinational read port, async clear.
module blockc_regarray
  import hierIncludeC_package::*;
#(
  parameter int unsigned NUM_REGS = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (we && (32'(wr_addr) < NUM_REGS)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Unimplemented addresses read as zero; the top flags them as errors anyway.
  assign rd_data = (32'(rd_addr) < NUM_REGS) ? mem[rd_addr] : '0;

endmodule

// File: rtl/blockc_req_ack_responder.sv
// Responder end of the b2C req/ack link: serves one request at a time against the
// register array and announces each committed write on a rdy/vld notification port.
module blockc_req_ack_responder
  import hierIncludeC_package::*;
#(
  parameter int unsigned NUM_REGS = 12,
  parameter int unsigned LATENCY  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic [REQ_W-1:0] req_data,
  output logic             ack,
  output logic [ACK_W-1:0] ack_data,
  output logic             ntf_vld,
  input  logic             ntf_rdy,
  output logic [NTF_W-1:0] ntf_data
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_e            state;
  state_e            state_n;
  req_t              hold;
  logic [CNT_W-1:0]  cnt;
  logic              addr_ok;
  logic              is_wr;
  logic              wr_en;
  logic [DATA_W-1:0] rdata;

  logic              ack_n;
  ack_t              ack_data_n;
  logic              ntf_vld_n;
  ntf_t              ntf_data_n;

  assign addr_ok = 32'(hold.addr) < NUM_REGS;
  assign is_wr   = hold.op == OP_WR;
  assign wr_en   = (state == ST_NOTIFY) && ntf_rdy;

  blockc_regarray #(
    .NUM_REGS (NUM_REGS)
  ) u_regarray (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (wr_en),
    .wr_addr (hold.addr),
    .wr_data (hold.wdata),
    .rd_addr (hold.addr),
    .rd_data (rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  // Request holding register and latency counter; counter only reloads on capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold <= '0;
      cnt  <= '0;
    end else if ((state == ST_IDLE) && req) begin
      hold <= req_t'(req_data);
      cnt  <= CNT_LOAD;
    end else if ((state == ST_BUSY) && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE:      if (req) state_n = ST_BUSY;
      ST_BUSY:      if (cnt == '0) state_n = (is_wr && addr_ok) ? ST_NOTIFY : ST_ACK;
      ST_NOTIFY:    if (ntf_rdy) state_n = ST_ACK;
      ST_ACK:       state_n = ST_WAIT_DROP;
      ST_WAIT_DROP: if (!req) state_n = ST_IDLE;
      default:      state_n = ST_IDLE;
    endcase
  end

  // Outputs are computed from the upcoming state so the registered copies line up with it.
  always_comb begin
    ack_n      = 1'b0;
    ack_data_n = '0;
    ntf_vld_n  = 1'b0;
    ntf_data_n = '0;
    if (state_n == ST_NOTIFY) begin
      ntf_vld_n        = 1'b1;
      ntf_data_n.addr  = hold.addr;
      ntf_data_n.wdata = hold.wdata;
    end
    if (state_n == ST_ACK) begin
      ack_n = 1'b1;
      if (!addr_ok) ack_data_n.err   = 1'b1;
      else          ack_data_n.rdata = is_wr ? hold.wdata : rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack      <= 1'b0;
      ack_data <= '0;
      ntf_vld  <= 1'b0;
      ntf_data <= '0;
    end else begin
      ack      <= ack_n;
      ack_data <= ACK_W'(ack_data_n);
      ntf_vld  <= ntf_vld_n;
      ntf_data <= NTF_W'(ntf_data_n);
    end
  end

endmodule

// File: doc/blockc_req_ack_responder.md
Name: blockc_req_ack_responder

Overview:
- Responder (destination) end of the b2C req/ack link driven by blockBX; sits in block C of the hierInclude hierarchy.
- Services single-outstanding read/write requests against an internal register array and returns a one-cycle ack carrying read data and an error flag.
- Publishes every committed write on a rdy/vld notification source toward downstream observers.

Parameters:
- ADDR_W, 4, request address width.
- DATA_W, 32, register/data width.
- NUM_REGS, 12, implemented registers; addresses >= NUM_REGS are errors (NUM_REGS <= 2**ADDR_W).
- LATENCY, 2, cycles from request capture to ack or notify; legal range 1..15.

Ports:
- clk  in  1  clock, single domain.
- rst_n  in  1  asynchronous active-low reset.
- req  in  1  b2C request, level, held by initiator until ack.
- req_data  in  1+ADDR_W+DATA_W  {op, addr, wdata}; op 1 = write, 0 = read.
- ack  out  1  one-cycle acknowledge pulse.
- ack_data  out  1+DATA_W  {err, rdata}; valid only while ack = 1.
- ntf_vld  out  1  write notification valid.
- ntf_rdy  in  1  notification ready.
- ntf_data  out  ADDR_W+DATA_W  {addr, wdata} of the committed write.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values:
  - ack = 0, ack_data = 0, ntf_vld = 0, ntf_data = 0.
  - All registers = 0; FSM in IDLE; latency counter = 0.
  - Reset mid-transaction aborts it: no ack, no notification, no register update.
- FSM states: IDLE, BUSY, NOTIFY, ACK, WAIT_DROP.
- IDLE:
  - On a clock edge with req = 1, capture req_data into a holding register, load counter = LATENCY-1, go to BUSY.
  - req_data is ignored after capture.
- BUSY:
  - Decrement the counter each cycle.
  - At counter = 0: a write to a valid address goes to NOTIFY; all other requests go to ACK.
  - Net effect: a read's ack is high in the cycle after capture edge + LATENCY.
- NOTIFY:
  - ntf_vld = 1 with ntf_data = {addr, wdata}, held stable until ntf_rdy = 1.
  - On the vld & rdy edge, write the register and go to ACK.
  - ntf_rdy held low stalls the ack indefinitely.
- ACK:
  - ack = 1 for exactly one cycle.
  - Valid read: ack_data = {0, reg[addr]}.
  - Valid write: ack_data = {0, wdata}.
  - Address out of range (read or write): ack_data = {1, 0}; no register change, no notification.
  - Next state is WAIT_DROP.
- WAIT_DROP:
  - Stay while req = 1 (the initiator drops req after seeing ack); go to IDLE on the first edge with req = 0.
  - The earliest next capture is therefore two edges after the ack cycle, so the same request is never served twice.
- Ordering and hazards:
  - A read issued after a write's ack returns the written value.
  - There is no forwarding hazard because only one request is outstanding.
- Boundaries:
  - addr = NUM_REGS-1 is valid; addr = NUM_REGS is an error.
  - LATENCY = 1: BUSY lasts one cycle.
  - The counter never wraps; it is reloaded only in IDLE.
  - req dropping before ack is a protocol violation; the responder completes and acks regardless.

Decomposition:
- Shared package (hierIncludeC_package):
  - req-op enum (OP_RD, OP_WR).
  - Packed structs for the request payload {op, addr, wdata}, the ack payload {err, rdata} and the notification payload {addr, wdata}.
  - FSM state enum.
- Sub-module: blockc_regarray, holding NUM_REGS x DATA_W flops with one synchronous write port, one combinational read port and async reset to 0.
- FSM, counter and handshake logic stay in the top module.

Test Plan:
- Reset-read: after reset, read addr 3 with LATENCY = 2 -> ack high exactly in the cycle after capture+2; ack_data = {0, 0x00000000}; ntf_vld never rises.
- Write then read:
  - Write addr 5 = 0xDEADBEEF with ntf_rdy = 1 -> ntf_vld for 1 cycle with ntf_data = {5, 0xDEADBEEF}; ack next cycle with {0, 0xDEADBEEF}.
  - Following read of addr 5 -> {0, 0xDEADBEEF}.
- Notify backpressure: ntf_rdy low for 7 cycles during a write to addr 2 = 0x1234 -> ntf_vld and ntf_data stable for all 7 cycles, no ack; ack 1 cycle after ntf_rdy rises; a subsequent read of addr 2 returns 0x1234.
- Out of range:
  - Write addr 12 (NUM_REGS = 12) data 0x55 -> ack_data = {1, 0}; no ntf_vld.
  - Read addr 11 -> {0, 0}; read addr 15 -> {1, 0}.
- Held req / back-to-back: initiator keeps req high 3 cycles past ack, then issues a new read 1 cycle after dropping -> exactly one ack for the first request; second request captured and acked normally.
- Reset mid-op: assert rst_n = 0 while in NOTIFY for a write to addr 1 = 0xAA -> ack and ntf_vld drop immediately (async); after release, read addr 1 returns {0, 0}.
